// File: rtl/bus_host_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the bus host arbiter.
package bus_host_arbiter_pkg;

    // Arbiter state: free round-robin picking, or a locked owner holding the bus.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Ceiling log2 for elaboration-time width calculation; clog2(1) == 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Host index width; never narrower than one bit, even for a single host.
    function automatic int host_sel_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_host_arbiter_rr_pick.sv
// Combinational rotate-priority picker: returns the first requester at or after
// the start index, wrapping modulo N (non-power-of-2 N supported).
module rr_pick
    import bus_host_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int SelW = host_sel_w(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [SelW-1:0] i_start,
    output logic            o_valid,
    output logic [SelW-1:0] o_idx,
    output logic [N-1:0]    o_onehot
);

    int               w_best;
    int               w_dist;
    logic [SelW-1:0]  w_idx;
    logic             w_valid;

    // Pick the requester with the smallest rotated distance from the start index.
    always_comb begin
        w_best = N;
        w_dist = 0;
        w_idx  = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + N - int'(i_start)) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_idx  = SelW'(j);
            end
        end
        w_valid = (w_best < N);
    end

    // Expand the chosen index into a one-hot grant vector.
    always_comb begin
        o_onehot = '0;
        for (int j = 0; j < N; j++) begin
            o_onehot[j] = w_valid && (w_idx == SelW'(j));
        end
    end

    assign o_valid = w_valid;
    assign o_idx   = w_idx;

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin bus host arbiter with bounded locked bursts and 1-cycle response
// tracking. Grants are combinational; rvalid/resp_sel follow one cycle later.
module bus_host_arbiter
    import bus_host_arbiter_pkg::*;
#(
    parameter  int NrHosts  = 2,
    parameter  int MaxBurst = 4,
    localparam int HostSelW = host_sel_w(NrHosts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NrHosts-1:0]  host_req_i,
    input  logic [NrHosts-1:0]  host_lock_i,
    output logic [NrHosts-1:0]  host_gnt_o,
    output logic [NrHosts-1:0]  host_rvalid_o,
    output logic                bus_req_o,
    output logic [HostSelW-1:0] bus_host_sel_o,
    output logic [HostSelW-1:0] bus_resp_sel_o,
    output logic                owned_o
);

    // Burst counter holds 0..MaxBurst.
    localparam int CntW = clog2(MaxBurst) + 1;

    arb_state_e          r_state, w_state_nxt;
    logic [HostSelW-1:0] r_prio, w_prio_nxt;
    logic [HostSelW-1:0] r_owner, w_owner_nxt;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NrHosts-1:0]  r_rvalid;
    logic [HostSelW-1:0] r_resp_sel;

    logic                w_pick_valid;
    logic [HostSelW-1:0] w_pick_idx;
    logic [NrHosts-1:0]  w_pick_oh;
    logic                w_pick_lock;
    logic [NrHosts-1:0]  w_owner_oh;
    logic                w_owner_req;
    logic                w_owner_lock;
    logic                w_burst_end;
    logic [NrHosts-1:0]  w_gnt;
    logic [HostSelW-1:0] w_sel;

    // Pointer increment wrapping modulo NrHosts (stays 0 for a single host).
    function automatic logic [HostSelW-1:0] wrap_inc(input logic [HostSelW-1:0] v);
        if (int'(v) >= NrHosts - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    rr_pick #(
        .N    (NrHosts),
        .SelW (HostSelW)
    ) u_pick (
        .i_req    (host_req_i),
        .i_start  (r_prio),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_oh)
    );

    // Decode the registered owner index into a one-hot mask.
    always_comb begin
        w_owner_oh = '0;
        for (int j = 0; j < NrHosts; j++) begin
            w_owner_oh[j] = (r_owner == HostSelW'(j));
        end
    end

    assign w_pick_lock  = |(host_lock_i & w_pick_oh);
    assign w_owner_req  = |(host_req_i & w_owner_oh);
    assign w_owner_lock = |(host_lock_i & w_owner_oh);
    assign w_cnt_inc    = r_cnt + CntW'(1);
    assign w_burst_end  = !w_owner_lock || (int'(w_cnt_inc) == MaxBurst);

    // Next-state and grant decode; a dropped owner request costs one bubble cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_gnt       = '0;
        w_sel       = '0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt = w_pick_oh;
                    w_sel = w_pick_idx;
                    if (w_pick_lock && (MaxBurst > 1)) begin
                        w_state_nxt = OWNED;
                        w_owner_nxt = w_pick_idx;
                        w_cnt_nxt   = CntW'(1);
                    end else begin
                        w_prio_nxt  = wrap_inc(w_pick_idx);
                    end
                end
            end
            OWNED: begin
                if (w_owner_req) begin
                    w_gnt     = w_owner_oh;
                    w_sel     = r_owner;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_burst_end) begin
                        w_state_nxt = IDLE;
                        w_prio_nxt  = wrap_inc(r_owner);
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_prio_nxt  = wrap_inc(r_owner);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_prio  <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Response tracking: the bus answers exactly one cycle after each grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid   <= '0;
            r_resp_sel <= '0;
        end else begin
            r_rvalid <= host_gnt_o;
            if (bus_req_o) begin
                r_resp_sel <= bus_host_sel_o;
            end
        end
    end

    // Grants are suppressed while reset is held.
    assign host_gnt_o     = rst_ni ? w_gnt : '0;
    assign bus_host_sel_o = rst_ni ? w_sel : '0;
    assign bus_req_o      = |host_gnt_o;
    assign host_rvalid_o  = r_rvalid;
    assign bus_resp_sel_o = r_resp_sel;
    assign owned_o        = (r_state == OWNED);

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench: drivers push expected grants/responses, negedge monitors pop and compare.
module tb_bus_host_arbiter;

    logic clk;
    logic rst_ni;
    int   cyc;
    int   n_chk;
    int   n_fail;

    // DUT A: three hosts, bursts of up to four.
    logic [2:0] req_a, lock_a, gnt_a, rv_a;
    logic       busreq_a, owned_a;
    logic [1:0] sel_a, rsel_a;

    // DUT B: two hosts, MaxBurst of one (locking never takes effect).
    logic [1:0] req_b, lock_b, gnt_b, rv_b;
    logic       busreq_b, owned_b;
    logic [0:0] sel_b, rsel_b;

    typedef struct {
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       owned;
    } gexp_t;

    typedef struct {
        logic [2:0] rv;
        logic [1:0] rsel;
        int         due;
    } rexp_t;

    gexp_t qa_g[$];
    rexp_t qa_r[$];
    gexp_t qb_g[$];
    rexp_t qb_r[$];

    bus_host_arbiter #(.NrHosts(3), .MaxBurst(4)) dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .host_req_i     (req_a),
        .host_lock_i    (lock_a),
        .host_gnt_o     (gnt_a),
        .host_rvalid_o  (rv_a),
        .bus_req_o      (busreq_a),
        .bus_host_sel_o (sel_a),
        .bus_resp_sel_o (rsel_a),
        .owned_o        (owned_a)
    );

    bus_host_arbiter #(.NrHosts(2), .MaxBurst(1)) dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .host_req_i     (req_b),
        .host_lock_i    (lock_b),
        .host_gnt_o     (gnt_b),
        .host_rvalid_o  (rv_b),
        .bus_req_o      (busreq_b),
        .bus_host_sel_o (sel_b),
        .bus_resp_sel_o (rsel_b),
        .owned_o        (owned_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle on DUT A and record what it must answer.
    task automatic step_a(input logic [2:0] req, input logic [2:0] lock,
                          input logic [2:0] eg, input logic [1:0] es, input logic eo);
        req_a  = req;
        lock_a = lock;
        qa_g.push_back(gexp_t'{eg, es, eo});
        if (eg != 3'b000) qa_r.push_back(rexp_t'{eg, es, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [1:0] req, input logic [1:0] lock,
                          input logic [1:0] eg, input logic es, input logic eo);
        req_b  = req;
        lock_b = lock;
        qb_g.push_back(gexp_t'{{1'b0, eg}, {1'b0, es}, eo});
        if (eg != 2'b00) qb_r.push_back(rexp_t'{{1'b0, eg}, {1'b0, es}, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    // Monitor for DUT A.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (qa_g.size() > 0) begin
            ge = qa_g.pop_front();
            chk("a_gnt", int'(gnt_a), int'(ge.gnt));
            chk("a_sel", int'(sel_a), int'(ge.sel));
            chk("a_busreq", int'(busreq_a), int'(ge.gnt != 3'b000));
            chk("a_owned", int'(owned_a), int'(ge.owned));
        end
        if (rv_a != 3'b000) begin
            if (qa_r.size() == 0) begin
                chk("a_rvalid_unexpected", int'(rv_a), 0);
            end else begin
                re = qa_r.pop_front();
                chk("a_rvalid", int'(rv_a), int'(re.rv));
                chk("a_resp_sel", int'(rsel_a), int'(re.rsel));
                chk("a_rvalid_cycle", cyc, re.due);
            end
        end else if (qa_r.size() > 0 && qa_r[0].due <= cyc) begin
            re = qa_r.pop_front();
            chk("a_rvalid_missing", int'(rv_a), int'(re.rv));
        end
        chk("a_gnt_onehot0", int'($onehot0(gnt_a)), 1);
        chk("a_rv_onehot0", int'($onehot0(rv_a)), 1);
        chk("a_gnt_has_req", int'(gnt_a & ~req_a), 0);
    end

    // Monitor for DUT B.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (qb_g.size() > 0) begin
            ge = qb_g.pop_front();
            chk("b_gnt", int'(gnt_b), int'(ge.gnt));
            chk("b_sel", int'(sel_b), int'(ge.sel));
            chk("b_owned", int'(owned_b), int'(ge.owned));
        end
        if (rv_b != 2'b00) begin
            if (qb_r.size() == 0) begin
                chk("b_rvalid_unexpected", int'(rv_b), 0);
            end else begin
                re = qb_r.pop_front();
                chk("b_rvalid", int'(rv_b), int'(re.rv));
                chk("b_resp_sel", int'(rsel_b), int'(re.rsel));
                chk("b_rvalid_cycle", cyc, re.due);
            end
        end else if (qb_r.size() > 0 && qb_r[0].due <= cyc) begin
            re = qb_r.pop_front();
            chk("b_rvalid_missing", int'(rv_b), int'(re.rv));
        end
        chk("b_gnt_has_req", int'(gnt_b & ~req_b), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst_ni = 1'b0;
        req_a  = 3'b111;
        lock_a = 3'b000;
        req_b  = 2'b00;
        lock_b = 2'b00;

        // Reset state, with requests pending.
        #3;
        chk("rst_gnt", int'(gnt_a), 0);
        chk("rst_busreq", int'(busreq_a), 0);
        chk("rst_sel", int'(sel_a), 0);
        chk("rst_rvalid", int'(rv_a), 0);
        chk("rst_resp_sel", int'(rsel_a), 0);
        chk("rst_owned", int'(owned_a), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_a  = 3'b000;
        rst_ni = 1'b1;

        // Plain round robin between hosts 0 and 1.
        step_a(3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
        step_a(3'b011, 3'b000, 3'b010, 2'd1, 1'b0);
        step_a(3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
        step_a(3'b011, 3'b000, 3'b010, 2'd1, 1'b0);
        step_a(3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // Only host 2 requests; pointer wraps to 0 and stays there.
        step_a(3'b100, 3'b000, 3'b100, 2'd2, 1'b0);
        step_a(3'b100, 3'b000, 3'b100, 2'd2, 1'b0);
        step_a(3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        chk("resp_sel_hold", int'(rsel_a), 2);
        chk("rvalid_idle", int'(rv_a), 0);

        // Locked burst capped at four grants, then host 1 gets its turn.
        step_a(3'b011, 3'b001, 3'b001, 2'd0, 1'b0);
        step_a(3'b011, 3'b001, 3'b001, 2'd0, 1'b1);
        step_a(3'b011, 3'b001, 3'b001, 2'd0, 1'b1);
        step_a(3'b011, 3'b001, 3'b001, 2'd0, 1'b1);
        step_a(3'b011, 3'b001, 3'b010, 2'd1, 1'b0);

        // Owner drops its request: one bubble, then host 1.
        step_a(3'b011, 3'b001, 3'b001, 2'd0, 1'b0);
        step_a(3'b010, 3'b000, 3'b000, 2'd0, 1'b1);
        step_a(3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        step_a(3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // Reset in the middle of a burst (count at 2).
        step_a(3'b001, 3'b001, 3'b001, 2'd0, 1'b0);
        step_a(3'b001, 3'b001, 3'b001, 2'd0, 1'b1);
        req_a  = 3'b011;
        lock_a = 3'b001;
        chk("pre_rst_rvalid", int'(rv_a), 1);
        #1;
        rst_ni = 1'b0;
        qa_r.delete();
        #1;
        chk("midrst_gnt", int'(gnt_a), 0);
        chk("midrst_busreq", int'(busreq_a), 0);
        chk("midrst_owned", int'(owned_a), 0);
        chk("midrst_rvalid", int'(rv_a), 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        step_a(3'b111, 3'b000, 3'b001, 2'd0, 1'b0);
        step_a(3'b111, 3'b000, 3'b010, 2'd1, 1'b0);
        step_a(3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // MaxBurst of one: lock ignored, strict alternation.
        step_b(2'b11, 2'b01, 2'b01, 1'b0, 1'b0);
        step_b(2'b11, 2'b01, 2'b10, 1'b1, 1'b0);
        step_b(2'b11, 2'b01, 2'b01, 1'b0, 1'b0);
        step_b(2'b11, 2'b01, 2'b10, 1'b1, 1'b0);
        step_b(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        step_a(3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("qa_g_drained", qa_g.size(), 0);
        chk("qa_r_drained", qa_r.size(), 0);
        chk("qb_g_drained", qb_g.size(), 0);
        chk("qb_r_drained", qb_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
